// File: rtl/axi4_stream_pkg.sv
// -----------------------------------------------------------------------------
// axi4_stream_pkg
// Shared constants and types for the axi4_stream link.
//   DATA_W_DEF : default stream data width
//   data_t     : data word at the default width
// -----------------------------------------------------------------------------
package axi4_stream_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage : axi4_stream_pkg

// File: rtl/axi4_stream_src.sv
// -----------------------------------------------------------------------------
// axi4_stream_src
// Stream source (master side). It always has a fresh word to offer. It reloads
// the word whenever the channel is idle or a beat is accepted. While a beat is
// stalled it holds the word steady.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   data_i  : producer word sampled on reload
//   ready_i : TREADY from the sink
//   valid_o : TVALID (registered)
//   data_o  : TDATA (registered)
// -----------------------------------------------------------------------------
module axi4_stream_src
    import axi4_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Reload when idle or when the current beat transfers this edge; otherwise
    // the beat is stalled and must stay stable. Valid never drops once set.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!valid_q || ready_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : axi4_stream_src

// File: rtl/axi4_stream.sv
// -----------------------------------------------------------------------------
// axi4_stream
// Self-contained AXI4-Stream link: an internal source feeds an internal sink
// over TVALID/TREADY/TDATA. The sink's readiness follows the downstream
// buffer-empty flag, and each accepted beat is latched into o_buffer.
// Ports:
//   in_clk        : clock, rising edge
//   in_rst        : synchronous active-high reset
//   in_data       : producer word sampled by the source
//   in_buffer_emp : downstream buffer empty (1 = sink may accept)
//   o_buffer      : last word accepted by the sink (registered)
// -----------------------------------------------------------------------------
module axi4_stream
    import axi4_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_buffer_emp,
    output logic [DATA_W-1:0] o_buffer
);

    // Channel signals keep their AXI names so they can be probed from above.
    logic              TVALID;
    logic              TREADY;
    logic [DATA_W-1:0] TDATA;

    logic [DATA_W-1:0] buffer_q, buffer_d;
    logic              xfer;

    axi4_stream_src #(
        .DATA_W (DATA_W)
    ) u_src (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .data_i  (in_data),
        .ready_i (TREADY),
        .valid_o (TVALID),
        .data_o  (TDATA)
    );

    assign xfer = TVALID & TREADY;

    always_comb begin
        buffer_d = buffer_q;
        if (xfer) begin
            buffer_d = TDATA;
        end
    end

    // TREADY is a plain registered copy of the buffer-empty flag, so it never
    // depends on TVALID. A falling flag still allows one more transfer.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            TREADY   <= 1'b0;
            buffer_q <= '0;
        end else begin
            TREADY   <= in_buffer_emp;
            buffer_q <= buffer_d;
        end
    end

    assign o_buffer = buffer_q;

endmodule : axi4_stream

// File: tb/tb_axi4_stream.sv
// -----------------------------------------------------------------------------
// tb_axi4_stream
// Directed bench for axi4_stream. Inputs change just after each rising edge;
// outputs and channel signals are sampled 1 ns after the edge and compared
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axi4_stream;
    import axi4_stream_pkg::*;

    logic  in_clk = 1'b0;
    logic  in_rst;
    data_t in_data;
    logic  in_buffer_emp;
    data_t o_buffer;

    int n_tests = 0;
    int n_fail  = 0;

    axi4_stream #(
        .DATA_W (DATA_W_DEF)
    ) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_data       (in_data),
        .in_buffer_emp (in_buffer_emp),
        .o_buffer      (o_buffer)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Check the whole observable state in one call.
    task automatic chk_all(input string tag, input logic v, input logic r,
                           input logic [31:0] d, input logic [31:0] b);
        chk({tag, ".tvalid"}, {31'd0, dut.TVALID}, {31'd0, v});
        chk({tag, ".tready"}, {31'd0, dut.TREADY}, {31'd0, r});
        chk({tag, ".tdata"},  {16'd0, dut.TDATA},  d);
        chk({tag, ".obuf"},   {16'd0, o_buffer},   b);
    endtask

    initial begin
        in_rst        = 1'b1;
        in_data       = 16'h1234;
        in_buffer_emp = 1'b1;

        // Reset held for two edges
        tick(); chk_all("rst0", 0, 0, 0, 0);
        tick(); chk_all("rst1", 0, 0, 0, 0);

        // Release into a stall
        in_rst = 1'b0; in_data = 16'd240; in_buffer_emp = 1'b0;
        tick(); chk_all("load", 1, 0, 240, 0);
        in_data = 16'd99;
        tick(); chk_all("stall0", 1, 0, 240, 0);
        tick(); chk_all("stall1", 1, 0, 240, 0);

        // Ready rises one edge after buffer-empty; transfer on the next
        in_buffer_emp = 1'b1;
        tick(); chk_all("rdy_up", 1, 1, 240, 0);
        tick(); chk_all("xfer1", 1, 1, 99, 240);

        // Streaming, one beat per cycle, 2-edge lag from in_data
        in_data = 16'd220;
        tick(); chk_all("strm0", 1, 1, 220, 99);
        tick(); chk_all("strm1", 1, 1, 220, 220);
        tick(); chk_all("strm2", 1, 1, 220, 220);
        in_data = 16'd260;
        tick(); chk_all("strm3", 1, 1, 260, 220);
        tick(); chk_all("strm4", 1, 1, 260, 260);

        // Ready drop: one more transfer, then freeze
        in_buffer_emp = 1'b0;
        tick(); chk_all("drop0", 1, 0, 260, 260);
        in_data = 16'd77;
        tick(); chk_all("drop1", 1, 0, 260, 260);
        tick(); chk_all("drop2", 1, 0, 260, 260);

        // Ready back, then reset during a transfer cycle
        in_buffer_emp = 1'b1;
        tick(); chk_all("rdy2", 1, 1, 260, 260);
        in_data = 16'd55;
        in_rst  = 1'b1;
        tick(); chk_all("rst_mid", 0, 0, 0, 0);

        // Recovery after the mid-stream reset
        in_rst = 1'b0;
        tick(); chk_all("rec0", 1, 1, 55, 0);
        tick(); chk_all("rec1", 1, 1, 55, 55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axi4_stream
